cute_key_sched: RTL and testbench
=================================

// Module: cute_key_sched
// PURPOSE
//  Key-provider end of the time-varying key interface of our locked behavioural FSMs.
//  - Stores NUM_KEYS keys loaded over a valid/ready port.
//  - Holds the locked core in reset until started, then releases it.
//  - Drives keyinput with the key for the current counter phase.
//  - Each key spans PHASE_LEN core clocks; the schedule repeats every NUM_KEYS*PHASE_LEN clocks.
//  - Sits beside the locked core; keyinput and lock_rst connect straight to the core's key inputs and rst.
// PARAMETERS
//  KEY_W      6  key width; keyinput[i] drives core keyinput<i>
//  NUM_KEYS   2  keys in the schedule, >=1
//  PHASE_LEN  4  core clocks per key, >=1
//  (derived) PERIOD=NUM_KEYS*PHASE_LEN; CNT_W=max(1,$clog2(PERIOD)); IDX_W=max(1,$clog2(NUM_KEYS))
// PORTS
//  clk        in   1      single clock; this block acts on the rising edge
//  rst        in   1      synchronous reset, active-low
//  cfg_valid  in   1      key word offered
//  cfg_data   in   KEY_W  key word; first accepted word = key 0
//  cfg_ready  out  1      block accepts a key word
//  cfg_clear  in   1      zeroise keys, return to EMPTY
//  start      in   1      begin schedule (LOADED only)
//  stop       in   1      end schedule, re-hold core in reset
//  keyinput   out  KEY_W  key presented to the locked core
//  lock_rst   out  1      active-high reset to the locked core
//  key_idx    out  IDX_W  index of the key on keyinput
//  loaded     out  1      all NUM_KEYS keys held
//  running    out  1      schedule active
// BEHAVIOUR
//  - Reset (rst=0 at a rising edge) acts in any state, including mid-RUN:
//    - state=EMPTY; key regs, load pointer and phase cnt cleared to 0.
//    - Outputs: cfg_ready=1, keyinput=0, lock_rst=1, key_idx=0, loaded=0, running=0.
//  - FSM states: EMPTY, LOADED, RUN.
//  - EMPTY: cfg_ready=1.
//    - On cfg_valid&cfg_ready, cfg_data is written to key[ptr] and ptr increments.
//    - Acceptance of word NUM_KEYS-1 moves to LOADED on the same edge; cfg_ready=0 from the next cycle.
//    - start is ignored.
//  - LOADED: loaded=1, lock_rst=1, keyinput=0.
//    - start -> RUN, with cnt=0 on that edge.
//    - cfg_valid is ignored.
//  - RUN: running=1, lock_rst=0.
//    - keyinput=key[cnt/PHASE_LEN], key_idx=cnt/PHASE_LEN; both come from registers only (no comb path from inputs).
//    - cnt increments each rising edge and wraps PERIOD-1 -> 0.
//  - Alignment: the core samples on the falling edge after lock_rst falls.
//    - That falling edge must see key 0; falling edge k must see key[(k/PHASE_LEN)%NUM_KEYS].
//  - Values are set on rising edges only, so keyinput is stable at each core falling edge.
//  - stop in RUN -> LOADED on the next edge: lock_rst=1, keyinput=0, cnt=0; keys retained.
//  - Priority: rst > cfg_clear > stop > start.
//    - cfg_clear in any state -> EMPTY, keys and ptr zeroed.
//    - start and stop in the same cycle: stop wins, start is dropped.
//  - start while already in RUN is ignored; cnt does not restart.
//  - keyinput is never driven with a partially loaded key set.
// TESTING
//  1. Load 6'd45 then 6'd33, assert start.
//     -> lock_rst falls; keyinput=45 for 4 clks, then 33 for 4 clks, then 45 again (wrap).
//  2. Load 45 only, assert start.
//     -> no response: running=0, lock_rst=1, cfg_ready=1.
//     Then load 33 -> loaded=1, cfg_ready=0 on the next cycle.
//  3. RUN with cnt=5, assert stop -> next cycle: lock_rst=1, keyinput=0, key_idx=0.
//     Assert start -> keyinput=45 from cnt=0.
//  4. start and stop together in RUN -> LOADED, lock_rst=1.
//     start alone in RUN at cnt=2 -> cnt=3 next (no restart).
//  5. rst=0 mid-RUN at cnt=6 -> next cycle: EMPTY, keys=0, keyinput=0, lock_rst=1, cfg_ready=1.
//     cfg_clear in LOADED -> EMPTY; reload works.
//  6. Connect to the indep locked core with keys 45/33 -> its y1..y23 match the unlocked FSM over 64 random cycles.
//     Load 45/45 -> mismatch seen within 8 clks.

Source files
------------

// File: rtl/cute_key_sched.sv
// Key provider for time-varying-key locked FSMs: loads NUM_KEYS keys, holds the
// locked core in reset until started, then cycles keyinput every PHASE_LEN clocks.
module cute_key_sched #(
    parameter int KEY_W     = 6,
    parameter int NUM_KEYS  = 2,
    parameter int PHASE_LEN = 4,
    localparam int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [KEY_W-1:0] cfg_data,
    output logic             cfg_ready,
    input  logic             cfg_clear,
    input  logic             start,
    input  logic             stop,
    output logic [KEY_W-1:0] keyinput,
    output logic             lock_rst,
    output logic [IDX_W-1:0] key_idx,
    output logic             loaded,
    output logic             running
);

    // cfg handshake: a word transfers on a rising edge where cfg_valid and
    // cfg_ready are both high; cfg_ready depends only on state, never on cfg_valid.

    localparam int PH_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PHASE_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_KEYS - 1);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_LOADED = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [KEY_W-1:0] key_q [NUM_KEYS];
    logic [KEY_W-1:0] key_d [NUM_KEYS];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            ptr_q   <= '0;
            phase_q <= '0;
            idx_q   <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_q[i] <= key_d[i];
            end
        end
    end

    // Next state; the schedule counter is split into key index and phase within key
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_d[i] = key_q[i];
        end

        if (cfg_clear) begin
            state_d = S_EMPTY;
            ptr_d   = '0;
            phase_d = '0;
            idx_d   = '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_d[i] = '0;
            end
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (cfg_valid) begin
                        key_d[ptr_q] = cfg_data;
                        if (ptr_q == IDX_LAST) begin
                            state_d = S_LOADED;
                            ptr_d   = '0;
                        end else begin
                            ptr_d = IDX_W'(ptr_q + 1);
                        end
                    end
                end
                S_LOADED: begin
                    // stop outranks start, so a simultaneous pair stays here
                    if (start && !stop) begin
                        state_d = S_RUN;
                        phase_d = '0;
                        idx_d   = '0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_LOADED;
                        phase_d = '0;
                        idx_d   = '0;
                    end else if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : IDX_W'(idx_q + 1);
                    end else begin
                        phase_d = PH_W'(phase_q + 1);
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // Outputs decode registers only, so keyinput settles right after each rising edge
    always_comb begin
        cfg_ready = (state_q == S_EMPTY);
        loaded    = (state_q == S_LOADED) || (state_q == S_RUN);
        running   = (state_q == S_RUN);
        lock_rst  = (state_q != S_RUN);
        keyinput  = '0;
        key_idx   = '0;
        if (state_q == S_RUN) begin
            keyinput = key_q[idx_q];
            key_idx  = idx_q;
        end
    end

endmodule

// File: tb/tb_cute_key_sched.sv
// Randomized and directed bench for cute_key_sched against a schedule model
// built from a queue of accepted keys and a count of clocks since start.
module tb_cute_key_sched;

  localparam int KEY_W     = 6;
  localparam int NUM_KEYS  = 2;
  localparam int PHASE_LEN = 4;
  localparam int PERIOD    = NUM_KEYS * PHASE_LEN;
  localparam int IDX_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  localparam int M_EMPTY  = 0;
  localparam int M_LOADED = 1;
  localparam int M_RUN    = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             cfg_valid = 1'b0;
  logic [KEY_W-1:0] cfg_data  = '0;
  logic             cfg_ready;
  logic             cfg_clear = 1'b0;
  logic             start     = 1'b0;
  logic             stop      = 1'b0;
  logic [KEY_W-1:0] keyinput;
  logic             lock_rst;
  logic [IDX_W-1:0] key_idx;
  logic             loaded;
  logic             running;

  cute_key_sched #(
    .KEY_W    (KEY_W),
    .NUM_KEYS (NUM_KEYS),
    .PHASE_LEN(PHASE_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_data (cfg_data),
    .cfg_ready(cfg_ready),
    .cfg_clear(cfg_clear),
    .start    (start),
    .stop     (stop),
    .keyinput (keyinput),
    .lock_rst (lock_rst),
    .key_idx  (key_idx),
    .loaded   (loaded),
    .running  (running)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: mode, accepted keys in order, clocks elapsed since start
  int               mode = M_EMPTY;
  logic [KEY_W-1:0] kq[$];
  int               n_run = 0;

  task automatic model_step(input logic r, v, input logic [KEY_W-1:0] d, input logic c, s, p);
    if (!r) begin
      mode = M_EMPTY;
      kq.delete();
      n_run = 0;
    end else if (c) begin
      mode = M_EMPTY;
      kq.delete();
    end else if (mode == M_EMPTY) begin
      if (v) begin
        kq.push_back(d);
        if (kq.size() == NUM_KEYS) mode = M_LOADED;
      end
    end else if (mode == M_LOADED) begin
      if (s && !p) begin
        mode  = M_RUN;
        n_run = 0;
      end
    end else begin
      if (p) mode = M_LOADED;
      else   n_run = n_run + 1;
    end
  endtask

  task automatic compare_all();
    int               slot;
    logic [KEY_W-1:0] exp_key;
    slot    = 0;
    exp_key = '0;
    if (mode == M_RUN) begin
      slot    = (n_run % PERIOD) / PHASE_LEN;
      exp_key = kq[slot];
    end
    check("cfg_ready", 32'(cfg_ready), 32'(mode == M_EMPTY));
    check("loaded",    32'(loaded),    32'(mode != M_EMPTY));
    check("running",   32'(running),   32'(mode == M_RUN));
    check("lock_rst",  32'(lock_rst),  32'(mode != M_RUN));
    check("keyinput",  32'(keyinput),  32'(exp_key));
    check("key_idx",   32'(key_idx),   32'(slot));
  endtask

  // driver: apply inputs after a falling edge, step model at the rising edge,
  // compare at the following falling edge (where the locked core samples)
  task automatic cycle(input logic r, v, input logic [KEY_W-1:0] d, input logic c, s, p);
    rst = r; cfg_valid = v; cfg_data = d; cfg_clear = c; start = s; stop = p;
    @(posedge clk);
    model_step(r, v, d, c, s, p);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [KEY_W-1:0] d);
    cycle(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [KEY_W-1:0] exp1 [9];
    exp1 = '{6'd45, 6'd45, 6'd45, 6'd45, 6'd33, 6'd33, 6'd33, 6'd33, 6'd45};

    @(negedge clk);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_lock_rst",  32'(lock_rst),  32'd1);
    check("rst_keyinput",  32'(keyinput),  32'd0);

    // load 45/33, start, follow one full period plus wrap
    load(6'd45);
    load(6'd33);
    go();
    check("t1_lock_rst", 32'(lock_rst), 32'd0);
    check("t1_key0", 32'(keyinput), 32'(exp1[0]));
    for (int i = 1; i < 9; i++) begin
      idle(1);
      check("t1_key_seq", 32'(keyinput), 32'(exp1[i]));
    end

    // partial load ignores start
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    load(6'd45);
    go();
    check("t2_running",   32'(running),   32'd0);
    check("t2_lock_rst",  32'(lock_rst),  32'd1);
    check("t2_cfg_ready", 32'(cfg_ready), 32'd1);
    load(6'd33);
    check("t2_loaded",    32'(loaded),    32'd1);
    check("t2_cfg_ready_low", 32'(cfg_ready), 32'd0);

    // stop at cnt=5, restart from key 0
    go();
    idle(5);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("t3_lock_rst", 32'(lock_rst), 32'd1);
    check("t3_keyinput", 32'(keyinput), 32'd0);
    check("t3_key_idx",  32'(key_idx),  32'd0);
    go();
    check("t3_restart_key", 32'(keyinput), 32'd45);

    // start+stop together -> LOADED; lone start in RUN does not restart
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("t4_lock_rst", 32'(lock_rst), 32'd1);
    go();
    idle(2);
    go();
    idle(1);
    check("t4_no_restart_idx", 32'(key_idx), 32'd1);

    // reset mid-RUN at cnt=6, then clear from LOADED and reload
    idle(2);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t5_cfg_ready", 32'(cfg_ready), 32'd1);
    check("t5_lock_rst",  32'(lock_rst),  32'd1);
    check("t5_keyinput",  32'(keyinput),  32'd0);
    load(6'd45);
    load(6'd33);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t5_clear_ready", 32'(cfg_ready), 32'd1);
    load(6'd12);
    load(6'd7);
    go();
    check("t5_reload_key", 32'(keyinput), 32'd12);
    idle(4);
    check("t5_reload_key1", 32'(keyinput), 32'd7);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 199) != 0),
            1'($urandom_range(0, 1)),
            KEY_W'($urandom),
            1'($urandom_range(0, 79) == 0),
            1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
